// File: rtl/riscv_defs.sv
// Shared encodings for the byte-serial memory controller and its requesters.
package riscv_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } mem_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  localparam logic LOAD  = 1'b0;
  localparam logic STORE = 1'b1;

  localparam logic [1:0] IO_TAG = 2'b11;

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic len_legal(input logic [2:0] l);
    return (l == LEN_B) || (l == LEN_H) || (l == LEN_W);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter/sequencer sharing the RAM/IO bus between fetch and the LSB.
// state | meaning
// IDLE  | bus idle; arbitrate, load/store buffer wins over fetch
// READ  | issue byte addresses, capture mem_din one cycle after each address
// WRITE | drive one store byte per cycle; hold while the IO buffer is full
// DONE  | one-cycle done pulse to the owner, no arbitration
module mem_ctrl
  import riscv_defs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_BIT_HI  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic                  if_sig,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_sig,
  input  logic                  load_or_store,
  input  logic [2:0]            len,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           store_val,
  output logic                  ls_done,
  output logic [31:0]           ls_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  mem_state_e            state, state_nxt;
  owner_e                owner;
  logic [ADDR_WIDTH-1:0] base, cur_addr;
  logic [2:0]            len_q, cnt;
  logic                  op_q;
  logic [31:0]           wdata, result, result_nxt;
  logic                  stall, wr_raw;

  assign cur_addr = base + ADDR_WIDTH'(cnt);
  assign stall    = io_buffer_full && (cur_addr[IO_BIT_HI -: 2] == IO_TAG);

  always_comb begin
    state_nxt  = state;
    mem_a      = '0;
    mem_dout   = '0;
    wr_raw     = 1'b0;
    result_nxt = result;
    case (state)
      ST_IDLE: begin
        if (ls_sig) state_nxt = (load_or_store == STORE) ? ST_WRITE : ST_READ;
        else if (if_sig) state_nxt = ST_READ;
      end
      ST_READ: begin
        // The final cycle only captures; no address is driven so IO reads are not repeated.
        if (cnt < len_q) mem_a = cur_addr;
        case (cnt)
          3'd1:    result_nxt[7:0]   = mem_din;
          3'd2:    result_nxt[15:8]  = mem_din;
          3'd3:    result_nxt[23:16] = mem_din;
          3'd4:    result_nxt[31:24] = mem_din;
          default: ;
        endcase
        if (clear) state_nxt = ST_IDLE;
        else if (cnt == len_q) state_nxt = ST_DONE;
      end
      ST_WRITE: begin
        mem_a    = cur_addr;
        mem_dout = byte_lane(wdata, cnt[1:0]);
        if (!stall) begin
          wr_raw = 1'b1;
          if (cnt == len_q - 3'd1) state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_wr  = wr_raw & rdy;
  assign if_done = rdy && (state == ST_DONE) && (owner == OWN_IF) && !clear;
  assign ls_done = rdy && (state == ST_DONE) && (owner == OWN_LS) && ((op_q == STORE) || !clear);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= OWN_IF;
      base    <= '0;
      len_q   <= '0;
      op_q    <= LOAD;
      wdata   <= '0;
      cnt     <= '0;
      result  <= '0;
      if_data <= '0;
      ls_data <= '0;
    end else if (rdy) begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          cnt    <= '0;
          result <= '0;
          if (ls_sig) begin
            owner <= OWN_LS;
            base  <= ls_addr;
            len_q <= len;
            op_q  <= load_or_store;
            wdata <= store_val;
          end else if (if_sig) begin
            owner <= OWN_IF;
            base  <= if_addr;
            len_q <= LEN_W;
            op_q  <= LOAD;
          end
        end
        ST_READ: begin
          cnt    <= cnt + 3'd1;
          result <= result_nxt;
          if (state_nxt == ST_DONE) begin
            if (owner == OWN_IF) if_data <= result_nxt;
            else ls_data <= result_nxt;
          end
        end
        ST_WRITE: if (!stall) cnt <= cnt + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: transaction table plus hand-written flush/stall/reset sequences.
module tb_mem_ctrl;
  import riscv_defs::*;

  localparam int NTR = 24;
  localparam int NV  = 9;

  typedef struct {
    logic        if_done;
    logic        ls_done;
    logic        mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [31:0] if_data;
    logic [31:0] ls_data;
  } snap_t;

  typedef struct {
    logic        is_fetch;
    logic        op;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] sval;
    logic [31:0] exp;
    int          exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, if_sig, ls_sig, load_or_store, io_buffer_full;
  logic [31:0] if_addr, ls_addr, store_val, if_data, ls_data, mem_a;
  logic [2:0]  len;
  logic        if_done, ls_done, mem_wr;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  ram [4096];
  logic        tb_we;
  logic [11:0] tb_wa;
  logic [7:0]  tb_wd;

  snap_t tr [NTR];
  vec_t  vt [NV];
  int    rel;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_sig(if_sig), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_sig(ls_sig), .load_or_store(load_or_store), .len(len), .ls_addr(ls_addr),
    .store_val(store_val), .ls_done(ls_done), .ls_data(ls_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // RAM model: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (tb_we) ram[tb_wa] <= tb_wd;
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  always @(negedge clk)
    if (!rst && ls_sig) assert (len_legal(len)) else $error("illegal len %0d", len);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic int first_done(input bit ls);
    for (int i = 0; i < NTR; i++)
      if (i < rel && (ls ? tr[i].ls_done : tr[i].if_done)) return i;
    return -1;
  endfunction

  function automatic int count_done(input bit ls);
    int c = 0;
    for (int i = 0; i < NTR; i++)
      if (i < rel && (ls ? tr[i].ls_done : tr[i].if_done)) c++;
    return c;
  endfunction

  // Sample the current cycle, then advance to just after the next edge; requesters drop on done.
  task automatic step();
    logic dif, dls;
    @(negedge clk);
    dif = if_done;
    dls = ls_done;
    if (rel < NTR) tr[rel] = '{if_done, ls_done, mem_wr, mem_a, mem_dout, if_data, ls_data};
    rel++;
    @(posedge clk);
    #1;
    if (dif) if_sig = 1'b0;
    if (dls) ls_sig = 1'b0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  initial begin
    vec_t        v;
    int          n;
    logic [31:0] a, w;

    rst = 1; rdy = 1; clear = 0; if_sig = 0; ls_sig = 0; load_or_store = 0; len = LEN_B;
    if_addr = 0; ls_addr = 0; store_val = 0; io_buffer_full = 0;
    tb_we = 0; tb_wa = 0; tb_wd = 0;
    rel = 0;
    @(posedge clk);
    #1;
    poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h10); poke(12'h103, 8'h00);
    poke(12'h200, 8'h34); poke(12'h201, 8'h12);
    poke(12'hFFE, 8'hAA); poke(12'hFFF, 8'hBB); poke(12'h000, 8'hCC); poke(12'h001, 8'hDD);

    @(negedge clk);
    chk("rst_if_done", {31'b0, if_done}, 0);
    chk("rst_ls_done", {31'b0, ls_done}, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ls_data", ls_data, 0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 0);
    @(posedge clk);
    #1;
    rst = 0;

    //          fetch  op     len    addr          sval          exp           done
    vt[0] = '{1'b1, LOAD,  LEN_W, 32'h0000_0100, 32'h0,        32'h0010_0513, 6};
    vt[1] = '{1'b0, LOAD,  LEN_B, 32'h0000_0101, 32'h0,        32'h0000_0005, 3};
    vt[2] = '{1'b0, LOAD,  LEN_H, 32'h0000_0102, 32'h0,        32'h0000_0010, 4};
    vt[3] = '{1'b0, LOAD,  LEN_W, 32'hFFFF_FFFE, 32'h0,        32'hDDCC_BBAA, 6};
    vt[4] = '{1'b0, LOAD,  LEN_B, 32'h0000_0100, 32'h0,        32'h0000_0013, 3};
    vt[5] = '{1'b0, STORE, LEN_H, 32'h0000_0500, 32'hCAFE_1234, 32'h0000_1234, 3};
    vt[6] = '{1'b0, STORE, LEN_B, 32'h0000_0501, 32'h0000_00A5, 32'h0000_00A5, 2};
    vt[7] = '{1'b0, STORE, LEN_W, 32'h0003_0004, 32'h89AB_CDEF, 32'h89AB_CDEF, 5};
    vt[8] = '{1'b1, LOAD,  LEN_W, 32'hFFFF_FFFE, 32'h0,        32'hDDCC_BBAA, 6};

    for (int k = 0; k < NV; k++) begin
      v = vt[k];
      n = v.is_fetch ? 4 : int'(v.len);
      rel = 0;
      if (v.is_fetch) begin
        if_sig = 1; if_addr = v.addr;
      end else begin
        ls_sig = 1; load_or_store = v.op; len = v.len; ls_addr = v.addr; store_val = v.sval;
      end
      repeat (12) step();
      chk($sformatf("v%0d_done_cyc", k), first_done(!v.is_fetch), v.exp_done);
      chk($sformatf("v%0d_done_cnt", k), count_done(!v.is_fetch), 1);
      chk($sformatf("v%0d_other_done", k), count_done(v.is_fetch), 0);
      if (v.op == LOAD)
        chk($sformatf("v%0d_data", k),
            v.is_fetch ? tr[v.exp_done].if_data : tr[v.exp_done].ls_data, v.exp);
      w = 0;
      for (int i = 0; i < n; i++) begin
        a = v.addr + 32'(i);
        chk($sformatf("v%0d_a%0d", k, i), tr[1+i].mem_a, a);
        chk($sformatf("v%0d_wr%0d", k, i), {31'b0, tr[1+i].mem_wr}, {31'b0, v.op});
        if (v.op == STORE) begin
          chk($sformatf("v%0d_dout%0d", k, i), {24'b0, tr[1+i].mem_dout}, {24'b0, v.sval[8*i +: 8]});
          w[8*i +: 8] = ram[a[11:0]];
        end
      end
      if (v.op == STORE) chk($sformatf("v%0d_ram", k), w, v.exp);
    end

    // Contention: LSB served first, fetch waits for the next IDLE.
    rel = 0;
    if_sig = 1; if_addr = 32'h100;
    ls_sig = 1; load_or_store = LOAD; len = LEN_H; ls_addr = 32'h200;
    repeat (16) step();
    chk("cont_ls_done", first_done(1), 4);
    chk("cont_ls_data", tr[4].ls_data, 32'h0000_1234);
    chk("cont_if_a0", tr[6].mem_a, 32'h100);
    chk("cont_if_a3", tr[9].mem_a, 32'h103);
    chk("cont_if_done", first_done(0), 11);
    chk("cont_if_data", tr[11].if_data, 32'h0010_0513);

    // IO store held off by a full UART buffer.
    rel = 0;
    ls_sig = 1; load_or_store = STORE; len = LEN_B; ls_addr = 32'h0003_0000; store_val = 32'h41;
    for (int t = 0; t < 10; t++) begin
      io_buffer_full = (t <= 3);
      step();
    end
    for (int t = 1; t <= 3; t++) chk($sformatf("io_stall_wr%0d", t), {31'b0, tr[t].mem_wr}, 0);
    chk("io_stall_a", tr[2].mem_a, 32'h0003_0000);
    chk("io_wr", {31'b0, tr[4].mem_wr}, 1);
    chk("io_dout", {24'b0, tr[4].mem_dout}, 32'h41);
    chk("io_done", first_done(1), 5);

    // Flush a fetch mid-read; clear in IDLE does not block the following load.
    rel = 0;
    if_sig = 1; if_addr = 32'h100;
    for (int t = 0; t < 12; t++) begin
      clear = (t == 2 || t == 3);
      if (t == 3) begin
        if_sig = 0; ls_sig = 1; load_or_store = LOAD; len = LEN_H; ls_addr = 32'h101;
      end
      step();
    end
    clear = 0;
    chk("flush_no_if_done", count_done(0), 0);
    chk("flush_idle_a", tr[3].mem_a, 0);
    chk("flush_load_a", tr[4].mem_a, 32'h101);
    chk("flush_load_done", first_done(1), 7);
    chk("flush_load_data", tr[7].ls_data, 32'h0000_1005);

    // A committed store ignores clear, including in DONE.
    rel = 0;
    ls_sig = 1; load_or_store = STORE; len = LEN_W; ls_addr = 32'h400; store_val = 32'hDEAD_BEEF;
    for (int t = 0; t < 10; t++) begin
      clear = (t == 2 || t == 5);
      step();
    end
    clear = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st_flush_wr%0d", i), {31'b0, tr[1+i].mem_wr}, 1);
      chk($sformatf("st_flush_a%0d", i), tr[1+i].mem_a, 32'h400 + 32'(i));
      chk($sformatf("st_flush_dout%0d", i), {24'b0, tr[1+i].mem_dout}, {24'b0, store_val[8*i +: 8]});
    end
    chk("st_flush_done", first_done(1), 5);

    // clear during a load's DONE suppresses its pulse.
    rel = 0;
    ls_sig = 1; load_or_store = LOAD; len = LEN_B; ls_addr = 32'h100;
    for (int t = 0; t < 8; t++) begin
      clear = (t == 3);
      if (t == 4) ls_sig = 0;
      step();
    end
    clear = 0;
    chk("ld_done_clr_cnt", count_done(1), 0);
    chk("ld_done_clr_a1", tr[1].mem_a, 32'h100);
    chk("ld_done_clr_idle", tr[4].mem_a, 0);

    // Synchronous reset in the middle of a fetch.
    rel = 0;
    if_sig = 1; if_addr = 32'h100;
    for (int t = 0; t < 10; t++) begin
      rst = (t == 2);
      if (t == 2) if_sig = 0;
      step();
    end
    chk("mid_rst_busy", tr[2].mem_a, 32'h101);
    chk("mid_rst_a", tr[3].mem_a, 0);
    chk("mid_rst_wr", {31'b0, tr[3].mem_wr}, 0);
    chk("mid_rst_dout", {24'b0, tr[3].mem_dout}, 0);
    chk("mid_rst_if_data", tr[3].if_data, 0);
    chk("mid_rst_ls_data", tr[3].ls_data, 0);
    chk("mid_rst_ls_done", count_done(1), 0);
    chk("mid_rst_if_done", count_done(0), 0);

    // rdy low for three cycles in the middle of a word store.
    rel = 0;
    ls_sig = 1; load_or_store = STORE; len = LEN_W; ls_addr = 32'h600; store_val = 32'h1122_3344;
    for (int t = 0; t < 12; t++) begin
      rdy = !(t >= 2 && t <= 4);
      step();
    end
    rdy = 1;
    chk("rdy_b0_a", tr[1].mem_a, 32'h600);
    chk("rdy_b0_dout", {24'b0, tr[1].mem_dout}, 32'h44);
    for (int t = 2; t <= 4; t++) chk($sformatf("rdy_low_wr%0d", t), {31'b0, tr[t].mem_wr}, 0);
    chk("rdy_low_a", tr[3].mem_a, 32'h601);
    chk("rdy_b1_wr", {31'b0, tr[5].mem_wr}, 1);
    chk("rdy_b1_dout", {24'b0, tr[5].mem_dout}, 32'h33);
    chk("rdy_b3_a", tr[7].mem_a, 32'h603);
    chk("rdy_done", first_done(1), 8);
    chk("rdy_done_cnt", count_done(1), 1);
    chk("rdy_ram", {ram[12'h603], ram[12'h602], ram[12'h601], ram[12'h600]}, 32'h1122_3344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port arbiter/sequencer for the byte-wide RAM/IO bus.
- Shares the bus between the instruction fetcher (4-byte reads) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each request into byte cycles, then returns one little-endian word and a one-cycle done pulse.
- Sits between ifetch/lsBuffer and the top-level RAM and IO ports.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- IO_BIT_HI, 17, upper bit of the 2-bit IO region tag; an address is IO when addr[IO_BIT_HI:IO_BIT_HI-1] == 2'b11.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; when low, all state freezes
- clear  in  1  misprediction flush from ROB
- if_sig  in  1  fetch request; held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched instruction
- ls_sig  in  1  LSB request; held until ls_done
- load_or_store  in  1  0 = load, 1 = store
- len  in  3  byte count: 1, 2 or 4
- ls_addr  in  32  load/store address
- store_val  in  32  store data; low len bytes used
- ls_done  out  1  one-cycle pulse
- ls_data  out  32  load result, zero-extended (LSB sign-extends)
- mem_din  in  8  RAM read byte; valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset: every output is 0 (if_done, ls_done, if_data, ls_data, mem_dout, mem_a, mem_wr); state IDLE; counters 0.
- rdy low: no state or register updates; mem_wr is forced 0 combinationally.
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration in cycle t:
  - ls_sig wins over if_sig (the LSB blocks commit).
  - Chosen: address, len (fetch len = 4), op, data and owner are latched; byte counter = 0; go to READ or WRITE.
  - No request: stay in IDLE.
- No preemption: a transaction runs to completion or abort.
- READ, n bytes:
  - Cycle t+1+i (i = 0..n-1): mem_a = base + i, mem_wr = 0.
  - mem_din sampled in cycle t+2+i into result byte i (little-endian).
  - Done pulse is high in cycle t+n+2; result bytes above n are 0.
- WRITE, n bytes:
  - For byte i: mem_a = base + i, mem_dout = store_val[8i+7:8i], mem_wr = 1.
  - Done pulse is high the cycle after the last byte is written (t+n+1 with no stalls).
  - If the address is IO and io_buffer_full = 1: that byte is not written (mem_wr = 0, mem_a held) and the counter does not advance until io_buffer_full = 0.
- DONE:
  - Exactly one done pulse, routed to the owner only; if_data/ls_data hold until the next done for that owner.
  - DONE lasts one cycle with no arbitration, so a requester can drop its sig, then return to IDLE.
- Idle bus: mem_wr = 0, mem_a = 0.
- clear:
  - Owner = ifetch or load: go to IDLE next cycle with no done pulse; a byte read already issued is discarded.
  - Owner = store: the store always completes (it is already committed).
  - clear in IDLE: no effect.
  - clear in DONE: the pending pulse is suppressed unless it is a store's.
- Simultaneous if_sig and ls_sig in IDLE: the LSB is served; the fetch waits (if_sig held) and is served at the first IDLE after the LSB's DONE.
- len values other than 1/2/4 are illegal; the verifier asserts on them.
- Address increment wraps modulo 2^32.

Decomposition:
- Shared package (riscv_defs): state encodings; LEN_B/LEN_H/LEN_W = 1/2/4; LOAD = 0, STORE = 1; IO region tag 2'b11.
- No sub-module. The byte-serialiser lives inline; an optional helper mem_byte_lane (byte select/insert) is allowed but not required.

Test Plan:
- Fetch only: RAM[0x100..0x103] = 13,05,10,00; if_sig, if_addr = 0x100 at t=0 -> mem_a 0x100..0x103 in t=1..4; if_done in t=6 with if_data = 0x00100513; ls_done stays 0.
- Contention: if_sig and ls_sig (load, len 2, 0x200, RAM = 0x34,0x12) both at t=0 -> ls_done at t=4 with ls_data = 0x00001234; fetch addresses start at t=6, if_done at t=11.
- Store byte to IO 0x30000, store_val = 0x41, io_buffer_full high t=0..3 -> mem_wr = 0 through t=3; mem_wr = 1, mem_dout = 0x41 at t=4; ls_done at t=5.
- Flush: fetch started at t=0, clear at t=2 -> no if_done, IDLE at t=3; a load issued at t=3 completes normally.
- Store survives flush: 4-byte store 0xDEADBEEF to 0x400, clear at t=2 -> bytes EF,BE,AD,DE written t=1..4; ls_done at t=5.
- rst asserted mid-READ, and rdy low for 3 cycles mid-WRITE -> after reset: all outputs 0, IDLE, no done; with rdy low: mem_wr = 0 and the byte index is unchanged, then the write resumes.
